// File: rtl/uart_tx_frame_engine.sv
// UART transmit engine: bit-rate prescaler, TX shift register and frame FSM.
// One word is accepted per data_valid/data_ready handshake and sent LSB first
// as start, data, optional parity, then one or two stop bits.
// Ports:
//   clk, reset (async, active-low)
//   prescale       clk cycles per bit minus 1
//   parity_enable  insert parity bit after data
//   parity_odd     1: odd parity, 0: even parity
//   two_stop_bits  1: two stop bits, 0: one
//   data_valid     data_in holds a word to send
//   data_in        word to transmit
//   data_ready     high only in IDLE (decoded from the state register)
//   tx_serial      registered serial line, idle high
//   busy           high from the cycle after accept until frame_done
//   frame_done     one-cycle pulse in the last cycle of the final stop bit
module uart_tx_frame_engine #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      parity_enable,
  input  logic                      parity_odd,
  input  logic                      two_stop_bits,
  input  logic                      data_valid,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic                      data_ready,
  output logic                      tx_serial,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                    state, state_n;
  logic [PRESCALE_WIDTH-1:0] cnt, cnt_n;
  logic [PRESCALE_WIDTH-1:0] presc_l, presc_n;
  logic [IDX_W-1:0]          idx, idx_n;
  logic [DATA_WIDTH-1:0]     shreg, shreg_n;
  logic                      pen_l, pen_n;
  logic                      two_l, two_n;
  logic                      par_l, par_n;
  logic                      stop2, stop2_n;
  logic                      tx_n, busy_n, done_n;
  logic                      bit_end;

  assign data_ready = (state == ST_IDLE);
  assign bit_end    = (cnt == '0);

  // State and datapath registers; reset forces the line idle at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      presc_l    <= '0;
      idx        <= '0;
      shreg      <= '0;
      pen_l      <= 1'b0;
      two_l      <= 1'b0;
      par_l      <= 1'b0;
      stop2      <= 1'b0;
      tx_serial  <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      presc_l    <= presc_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      pen_l      <= pen_n;
      two_l      <= two_n;
      par_l      <= par_n;
      stop2      <= stop2_n;
      tx_serial  <= tx_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

  // Next-state logic; registered outputs are derived from the next state so
  // they line up with the bit being driven.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    presc_n = presc_l;
    idx_n   = idx;
    shreg_n = shreg;
    pen_n   = pen_l;
    two_n   = two_l;
    par_n   = par_l;
    stop2_n = stop2;

    case (state)
      ST_IDLE: begin
        if (data_valid) begin
          state_n = ST_START;
          cnt_n   = prescale;
          presc_n = prescale;
          shreg_n = data_in;
          pen_n   = parity_enable;
          two_n   = two_stop_bits;
          par_n   = (^data_in) ^ parity_odd;
          stop2_n = 1'b0;
          idx_n   = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_n = ST_DATA;
          cnt_n   = presc_l;
          idx_n   = '0;
        end else begin
          cnt_n = cnt - PRESCALE_WIDTH'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_n   = presc_l;
          shreg_n = shreg >> 1;
          if (idx == LAST_IDX) begin
            state_n = pen_l ? ST_PARITY : ST_STOP;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt - PRESCALE_WIDTH'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_n = ST_STOP;
          cnt_n   = presc_l;
        end else begin
          cnt_n = cnt - PRESCALE_WIDTH'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (two_l && !stop2) begin
            stop2_n = 1'b1;
            cnt_n   = presc_l;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt - PRESCALE_WIDTH'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shreg_n[0];
      ST_PARITY: tx_n = par_l;
      default:   tx_n = 1'b1;
    endcase

    busy_n = (state_n != ST_IDLE);
    // Final cycle of the last stop bit: counter exhausted and no second stop pending.
    done_n = (state_n == ST_STOP) && (cnt_n == '0) && (stop2_n || !two_n);
  end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Self-checking bench for uart_tx_frame_engine: a per-cycle frame model built
// from queued bit lists, plus literal timing and bit-pattern checks.
module tb_uart_tx_frame_engine;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] prescale;
  logic          parity_enable, parity_odd, two_stop_bits, data_valid;
  logic [DW-1:0] data_in;
  logic          data_ready, tx_serial, busy, frame_done;

  always #5 clk = ~clk;

  uart_tx_frame_engine #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .prescale(prescale),
    .parity_enable(parity_enable), .parity_odd(parity_odd),
    .two_stop_bits(two_stop_bits), .data_valid(data_valid), .data_in(data_in),
    .data_ready(data_ready), .tx_serial(tx_serial), .busy(busy),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
    logic ready;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   cyc = 0;
  int   acc_count = 0;
  int   acc_cyc = 0;
  int   done_count = 0;
  int   last_done = -1;
  int   total = 0;
  int   bad = 0;
  logic txlog [0:4095];

  function automatic exp_t idle_e();
    exp_t e;
    e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.ready = 1'b1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  // Expand one frame into per-cycle expectations from the latched settings.
  task automatic build(input logic [DW-1:0] d, input int p, input logic pen,
                       input logic odd, input logic two);
    logic bits[$];
    int   ones;
    exp_t e;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < int'(DW); i++) begin
      bits.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pen) bits.push_back(odd ? ((ones % 2) == 0) : ((ones % 2) == 1));
    bits.push_back(1'b1);
    if (two) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int r = 0; r <= p; r++) begin
        e.tx    = bits[b];
        e.busy  = 1'b1;
        e.ready = 1'b0;
        e.done  = (b == bits.size() - 1) && (r == p);
        q.push_back(e);
      end
    end
  endtask

  // Model: advance one cycle per edge; accept only when the model is idle.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      cur = idle_e();
    end else begin
      if (cur.ready && data_valid) begin
        build(data_in, int'(prescale), parity_enable, parity_odd, two_stop_bits);
        acc_count = acc_count + 1;
        acc_cyc   = cyc;
      end
      cyc = cyc + 1;
      if (q.size() > 0) cur = q.pop_front();
      else              cur = idle_e();
    end
  end

  // Per-cycle compare against the model, on the inactive edge.
  initial begin
    forever begin
      @(negedge clk);
      txlog[cyc % 4096] = tx_serial;
      if (frame_done === 1'b1) begin
        done_count++;
        last_done = cyc;
      end
      if (reset === 1'b1) begin
        chk("m_tx",    32'(tx_serial),  32'(cur.tx));
        chk("m_busy",  32'(busy),       32'(cur.busy));
        chk("m_done",  32'(frame_done), 32'(cur.done));
        chk("m_ready", 32'(data_ready), 32'(cur.ready));
      end
    end
  end

  task automatic send(input logic [DW-1:0] d);
    int  start;
    bit  ok;
    start = acc_count;
    ok = 1'b0;
    data_in = d;
    data_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (acc_count != start) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cur.ready && q.size() == 0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // Check the line in the middle of each bit period against a literal pattern.
  task automatic chk_bits(input string name, input int a, input logic [11:0] pat,
                          input int nbits, input int per);
    for (int k = 0; k < nbits; k++)
      chk(name, 32'(txlog[(a + 1 + k * per + per / 2) % 4096]), 32'(pat[k]));
  endtask

  int a1, a2, dc, tgt;
  logic [11:0] pat;

  initial begin
    reset = 1'b0; data_valid = 1'b0; data_in = '0; prescale = 16'd3;
    parity_enable = 1'b0; parity_odd = 1'b0; two_stop_bits = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx_serial), 32'd1);
    chk("rst_ready", 32'(data_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: 0xA5, prescale 3, no parity, one stop
    send(8'hA5); data_valid = 1'b0; a1 = acc_cyc;
    wait_idle();
    chk("t1_done_lat", 32'(last_done - a1), 32'd40);
    pat = 12'b00_1_10100101_0;
    chk_bits("t1_bits", a1, pat, 10, 4);

    // 2: even then odd parity
    parity_enable = 1'b1; parity_odd = 1'b0;
    send(8'hA5); data_valid = 1'b0; a1 = acc_cyc;
    wait_idle();
    chk("t2e_done_lat", 32'(last_done - a1), 32'd44);
    chk("t2e_par", 32'(txlog[(a1 + 1 + 36 + 2) % 4096]), 32'd0);
    parity_odd = 1'b1;
    send(8'hA5); data_valid = 1'b0; a1 = acc_cyc;
    wait_idle();
    chk("t2o_done_lat", 32'(last_done - a1), 32'd44);
    chk("t2o_par", 32'(txlog[(a1 + 1 + 36 + 2) % 4096]), 32'd1);

    // 3: two stop bits, prescale 0, 0xFF
    parity_enable = 1'b0; parity_odd = 1'b0; two_stop_bits = 1'b1; prescale = 16'd0;
    send(8'hFF); data_valid = 1'b0; a1 = acc_cyc;
    wait_idle();
    chk("t3_done_lat", 32'(last_done - a1), 32'd11);
    chk("t3_start", 32'(txlog[(a1 + 1) % 4096]), 32'd0);
    for (int c = 3; c <= 11; c++) chk("t3_high", 32'(txlog[(a1 + c) % 4096]), 32'd1);
    chk("t3_busy_after", 32'(busy), 32'd0);

    // 4: back-to-back 0x01 then 0x80
    two_stop_bits = 1'b0; prescale = 16'd3;
    dc = acc_count;
    send(8'h01); a1 = acc_cyc;
    send(8'h80); a2 = acc_cyc;
    data_valid = 1'b0;
    chk("t4_gap", 32'(a2 + 1 - last_done), 32'd2);
    wait_idle();
    chk("t4_accepts", 32'(acc_count - dc), 32'd2);
    chk("t4_done2", 32'(last_done - a2), 32'd40);
    pat = 12'b00_1_00000001_0;
    chk_bits("t4_w1", a1, pat, 10, 4);
    pat = 12'b00_1_10000000_0;
    chk_bits("t4_w2", a2, pat, 10, 4);

    // 5: settings changed mid-frame only affect the next frame
    send(8'h5A); data_valid = 1'b0; a1 = acc_cyc;
    repeat (6) @(posedge clk);
    #1;
    prescale = 16'd1; parity_enable = 1'b1; parity_odd = 1'b1; two_stop_bits = 1'b1;
    wait_idle();
    chk("t5_old_lat", 32'(last_done - a1), 32'd40);
    send(8'h5A); data_valid = 1'b0; a1 = acc_cyc;
    wait_idle();
    chk("t5_new_lat", 32'(last_done - a1), 32'd24);
    pat = 12'b1_1_1_01011010_0;
    chk_bits("t5_bits", a1, pat, 12, 2);

    // 6: reset during data bit 3 aborts the frame
    prescale = 16'd3; parity_enable = 1'b0; parity_odd = 1'b0; two_stop_bits = 1'b0;
    send(8'hA5); data_valid = 1'b0; a1 = acc_cyc;
    tgt = a1 + 18;
    for (int i = 0; i < 100 && cyc < tgt; i++) begin
      @(posedge clk); #1;
    end
    chk("t6_pre_tx", 32'(tx_serial), 32'd0);
    dc = done_count;
    reset = 1'b0;
    #1;
    chk("t6_abort_tx", 32'(tx_serial), 32'd1);
    chk("t6_abort_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("t6_no_done", 32'(done_count), 32'(dc));
    chk("t6_ready", 32'(data_ready), 32'd1);
    send(8'h3C); data_valid = 1'b0; a1 = acc_cyc;
    wait_idle();
    chk("t6_done_lat", 32'(last_done - a1), 32'd40);
    pat = 12'b00_1_00111100_0;
    chk_bits("t6_bits", a1, pat, 10, 4);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
